// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: pixel scan-out reads, full-screen clear, host writes.
// Slot priority per clk is scan-out read > clear write > host write.
module vram_arbiter #(
  parameter int unsigned CELLS_X = 160,
  parameter int unsigned CELLS_Y = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  input  logic        clr_req,
  input  logic [11:0] clr_color,
  output logic        busy,
  output logic        clr_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [11:0] rgb
);

  localparam int unsigned AW     = 15;
  localparam int unsigned CW     = 12;
  localparam int unsigned NCELLS = CELLS_X * CELLS_Y;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NCELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [CW-1:0]   clr_col;
  logic            tick_d;
  logic            von_d;
  logic [AW-1:0]   row_base;
  logic [AW-1:0]   scan_addr;
  logic            scan_rd;
  logic            clr_wr;
  logic            host_go;
  logic            host_wr;
  logic            unused_lsbs;

  assign unused_lsbs = ^{x[1:0], y[1:0]};

  // Row base = (y>>2)*CELLS_X as a sum of shifted copies, one per set bit of CELLS_X
  always_comb begin
    row_base = '0;
    for (int i = 0; i < int'(AW); i++) begin
      if (CELLS_X[i]) row_base = row_base + (AW'(y[9:2]) << i);
    end
    scan_addr = row_base + AW'(x[9:2]);
  end

  // Slot grant and RAM port mux
  always_comb begin
    scan_rd   = p_tick & video_on & ~rst;
    clr_wr    = (state == CLEAR) & ~scan_rd & ~rst;
    host_go   = (state == IDLE) & wr_req & ~scan_rd & ~rst;
    host_wr   = host_go & (wr_addr < AW'(NCELLS));
    wr_ack    = host_go;
    mem_en    = scan_rd | clr_wr | host_wr;
    mem_we    = clr_wr | host_wr;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    if (scan_rd) begin
      mem_addr = scan_addr;
    end else if (clr_wr) begin
      mem_addr  = clr_cnt;
      mem_wdata = clr_col;
    end
  end

  // Clear FSM and the two-stage pixel return path
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_col  <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      rgb      <= '0;
      tick_d   <= 1'b0;
      von_d    <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      tick_d   <= p_tick;
      von_d    <= video_on;
      if (tick_d) rgb <= von_d ? mem_rdata : '0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
            clr_col <= clr_color;
          end
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_cnt == LAST_ADDR) begin
              state    <= IDLE;
              busy     <= 1'b0;
              clr_done <= 1'b1;
              clr_cnt  <= '0;
            end else begin
              clr_cnt <= clr_cnt + AW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a cell-level model of the framebuffer,
// the clear progress and the pixel return latency.
module tb_vram_arbiter;

  localparam int CX     = 160;
  localparam int CY     = 120;
  localparam int NCELLS = CX * CY;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        busy;
  logic        clr_done;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb;

  vram_arbiter #(.CELLS_X(CX), .CELLS_Y(CY)) dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .video_on(video_on), .x(x), .y(y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_req(clr_req), .clr_color(clr_color), .busy(busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the arbiter
  logic [11:0] ram [0:NCELLS-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        if (int'(mem_addr) < NCELLS) ram[mem_addr] <= mem_wdata;
      end else if (int'(mem_addr) < NCELLS) begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference state: what every cell should hold, how much of the clear is left
  logic [11:0] shadow [0:NCELLS-1];
  int          clr_left  = 0;
  logic [11:0] clr_col_m = '0;
  bit          done_next = 1'b0;
  bit          wr_pend   = 1'b0;
  logic [14:0] wa = '0;
  logic [11:0] wd = '0;
  bit          p1v = 1'b0, p2v = 1'b0;
  logic [11:0] p1 = '0, p2 = '0, exp_rgb = '0;
  int          clr_writes = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clk: drive inputs, predict every output, compare at the falling edge
  task automatic step(input bit tk, input bit von, input int xx, input int yy);
    int sa, caddr;
    bit scan, clearing, cwr, ack, hwr;
    p_tick = tk; video_on = von; x = 10'(xx); y = 10'(yy);
    wr_req = wr_pend; wr_addr = wa; wr_data = wd;
    if (p2v) exp_rgb = p2;
    p2v = p1v; p2 = p1; p1v = 1'b0;
    sa       = (yy / 4) * CX + (xx / 4);
    scan     = tk && von;
    clearing = clr_left > 0;
    if (tk) begin
      p1v = 1'b1;
      p1  = von ? shadow[sa] : 12'h000;
    end
    cwr   = clearing && !scan;
    caddr = NCELLS - clr_left;
    ack   = !clearing && wr_pend && !scan;
    hwr   = ack && (int'(wa) < NCELLS);
    @(negedge clk);
    check("busy", 32'(busy), 32'(clearing));
    check("clr_done", 32'(clr_done), 32'(done_next));
    check("wr_ack", 32'(wr_ack), 32'(ack));
    check("mem_en", 32'(mem_en), 32'(scan || cwr || hwr));
    check("mem_we", 32'(mem_we), 32'(cwr || hwr));
    if (scan) check("scan_addr", 32'(mem_addr), 32'(sa));
    if (cwr) begin
      check("clr_addr", 32'(mem_addr), 32'(caddr));
      check("clr_data", 32'(mem_wdata), 32'(clr_col_m));
    end
    if (hwr) begin
      check("host_addr", 32'(mem_addr), 32'(wa));
      check("host_data", 32'(mem_wdata), 32'(wd));
    end
    check("rgb", 32'(rgb), 32'(exp_rgb));
    if (busy && mem_en && mem_we) clr_writes++;
    if (clr_done) done_cnt++;
    done_next = 1'b0;
    if (cwr) begin
      shadow[caddr] = clr_col_m;
      clr_left--;
      if (clr_left == 0) done_next = 1'b1;
    end
    if (hwr) shadow[wa] = wd;
    if (ack) wr_pend = 1'b0;
    if (!clearing && clr_req) begin
      clr_left  = NCELLS;
      clr_col_m = clr_color;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; p_tick = 1'b0; video_on = 1'b0; clr_req = 1'b0; wr_req = wr_pend;
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_wr_ack", 32'(wr_ack), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    clr_left = 0; done_next = 1'b0;
    p1v = 1'b0; p2v = 1'b0; exp_rgb = '0;
  endtask

  task automatic start_clear(input logic [11:0] col, input bit von);
    clr_color = col; clr_req = 1'b1;
    step(1'b0, von, 0, 0);
    clr_req = 1'b0;
  endtask

  // von_mode: 0 blank, 1 active, 2 random; ignored clr_req and a stalled write are injected
  task automatic run_clear(input int von_mode, input bit inject);
    int k = 0;
    bit von;
    while (clr_left > 0 && k < 40000) begin
      von = (von_mode == 2) ? ($urandom_range(0, 3) != 0) : von_mode[0];
      if (inject && k == 100) clr_req = 1'b1;
      if (inject && k == 200) begin
        wr_pend = 1'b1; wa = 15'd7; wd = 12'h123;
      end
      step((k % 4) == 0, von, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      clr_req = 1'b0;
      k++;
    end
    check("clear_timeout", 32'(clr_left), 32'(0));
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; clr_color = '0;
    for (int i = 0; i < NCELLS; i++) shadow[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rgb", 32'(rgb), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_clr_done", 32'(clr_done), 32'(0));
    check("reset_wr_ack", 32'(wr_ack), 32'(0));
    check("reset_mem_en", 32'(mem_en), 32'(0));
    check("reset_mem_we", 32'(mem_we), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Bring the RAM to a known all-zero picture while blanked
    start_clear(12'h000, 1'b0);
    run_clear(0, 1'b0);

    // Scan-out of a preloaded cell with fixed two-clk latency
    wr_pend = 1'b1; wa = 15'd161; wd = 12'hF00;
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 4, 4);
    check("scan_rgb_early", 32'(rgb), 32'(0));
    step(1'b0, 1'b1, 5, 4);
    check("scan_rgb_2clk", 32'(rgb), 32'h0F00);
    step(1'b0, 1'b1, 6, 4);

    // Blanking tick loads zero; a pending write takes a blanked tick slot
    step(1'b1, 1'b0, 4, 4);
    step(1'b0, 1'b0, 0, 0);
    check("blank_rgb", 32'(rgb), 32'(0));
    step(1'b0, 1'b0, 0, 0);
    wr_pend = 1'b1; wa = 15'd200; wd = 12'h0AB;
    step(1'b1, 1'b0, 0, 0);
    check("blank_wr_done", 32'(wr_pend), 32'(0));
    step(1'b0, 1'b0, 0, 0); step(1'b0, 1'b0, 0, 0);

    // Host write deferred by a scan-out slot
    wr_pend = 1'b1; wa = 15'd300; wd = 12'h5C3;
    step(1'b1, 1'b1, 8, 8);
    check("prio_still_pending", 32'(wr_pend), 32'(1));
    step(1'b0, 1'b1, 9, 8);
    step(1'b0, 1'b1, 10, 8); step(1'b0, 1'b1, 11, 8);

    // Out-of-range host address
    wr_pend = 1'b1; wa = 15'd19200; wd = 12'hFFF;
    step(1'b0, 1'b1, 0, 0);

    // Random traffic in IDLE
    for (int k = 0; k < 1600; k++) begin
      if (!wr_pend && $urandom_range(0, 2) == 0) begin
        wr_pend = 1'b1;
        wa = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(NCELLS, 32767))
                                         : 15'($urandom_range(0, NCELLS - 1));
        wd = 12'($urandom);
      end
      step((k % 4) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    end
    while (wr_pend) step(1'b0, 1'b0, 0, 0);

    // Clear during active video, issued together with a host write
    wr_pend = 1'b1; wa = 15'd5; wd = 12'h777;
    clr_writes = 0; done_cnt = 0;
    start_clear(12'h0A5, 1'b1);
    clr_color = 12'hFFF;
    run_clear(1, 1'b1);
    check("clr_write_count", 32'(clr_writes), 32'(NCELLS));
    check("clr_done_count", 32'(done_cnt), 32'(1));
    check("stall_write_done", 32'(wr_pend), 32'(0));
    bad = 0;
    for (int i = 0; i < NCELLS; i++) if (i != 7 && ram[i] !== 12'h0A5) bad++;
    check("clr_readback_bad", 32'(bad), 32'(0));
    check("stall_cell", 32'(ram[7]), 32'h0123);

    // Reset after 500 clear writes, then restart from address 0
    done_cnt = 0;
    start_clear(12'h3C3, 1'b1);
    for (int k = 0; k < 2000 && clr_left > NCELLS - 500; k++)
      step((k % 4) == 0, 1'b1, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    check("abort_at_500", 32'(NCELLS - clr_left), 32'(500));
    do_reset();
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_rgb", 32'(rgb), 32'(0));
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 0, 0);
    check("abort_no_done", 32'(done_cnt), 32'(0));
    clr_writes = 0;
    start_clear(12'h5A5, 1'b0);
    run_clear(2, 1'b0);
    check("restart_write_count", 32'(clr_writes), 32'(NCELLS));
    check("restart_done_count", 32'(done_cnt), 32'(1));
    bad = 0;
    for (int i = 0; i < NCELLS; i++) if (ram[i] !== shadow[i]) bad++;
    check("final_ram_vs_model", 32'(bad), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: CELLS_X, default 160, framebuffer cells per row (4x4-pixel cells).
REQ-002 Parameter: CELLS_Y, default 120, framebuffer cell rows.
REQ-003 Port: clk  input  1  system clock (100 MHz). This is the only clock.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: p_tick  input  1  pixel tick from the sync generator; 1 clk wide, every 4th clk.
REQ-006 Port: video_on  input  1  display-region flag from the sync generator.
REQ-007 Port: x, y  input  10 each  current pixel coordinates.
REQ-008 Port: wr_req  input  1  host write request; held with wr_addr/wr_data stable until wr_ack.
REQ-009 Port: wr_addr  input  15  host cell address; wr_data  input  12  RGB444 value.
REQ-010 Port: wr_ack  output  1  one-clk pulse when the host write is accepted.
REQ-011 Port: clr_req  input  1  pulse requesting a fill of the whole framebuffer; clr_color  input  12  fill value, sampled when the request is accepted.
REQ-012 Port: busy  output  1  high while in CLEAR; clr_done  output  1  one-clk pulse at the end of a clear.
REQ-013 Port: mem_en, mem_we  output  1 each; mem_addr  output  15; mem_wdata  output  12  single-port RAM interface, combinational from inputs and state.
REQ-014 Port: mem_rdata  input  12  RAM read data, valid 1 clk after a read.
REQ-015 Port: rgb  output  12  registered pixel colour to the DAC.

Function
REQ-016 Scan-out address: mem_addr = (y>>2)*CELLS_X + (x>>2). With the default parameters the range is 0..19199, implemented without a multiplier (shift-add).
REQ-017 Slot priority per clk: scan-out read > clear write > host write; at most one RAM access per clk.
REQ-018 Scan-out: on a clk with p_tick=1 and video_on=1, the block SHALL drive mem_en=1, mem_we=0, mem_addr per REQ-016.
REQ-019 rgb SHALL load mem_rdata on the 2nd rising edge after a scan-out read (fixed latency of 2 clk, within a single pixel period); it SHALL load 0 at the same point after a p_tick with video_on=0; otherwise rgb holds its value.
REQ-020 FSM states: IDLE and CLEAR. IDLE->CLEAR on clr_req=1. CLEAR->IDLE after the write to the last address (CELLS_X*CELLS_Y-1); clr_done pulses on the clk following that write.
REQ-021 CLEAR: on every clk not taken by scan-out, write clr_color to the clear counter address and increment the counter; the counter starts at 0.
REQ-022 clr_req received during CLEAR SHALL be ignored (no restart, no counter change).
REQ-023 Host write: in IDLE, on a clk with wr_req=1 and no scan-out read, the block SHALL drive mem_en=1, mem_we=1, wr_addr, wr_data and pulse wr_ack in that same clk.
REQ-024 A host write with wr_addr >= CELLS_X*CELLS_Y SHALL be acked without asserting mem_en.
REQ-025 Host writes SHALL stall (no wr_ack) while busy=1; the pending request completes after clr_done.
REQ-026 Simultaneous clr_req and wr_req in IDLE: the host write is served first on that clk if the slot is free, and CLEAR begins on the next clk.
REQ-027 mem_en=0 whenever no access is granted; mem_wdata is don't-care when mem_we=0.

Reset
REQ-028 While rst=1: state=IDLE, clear counter=0, rgb=0, wr_ack=0, busy=0, clr_done=0, mem_en=0, mem_we=0.
REQ-029 rst asserted mid-clear SHALL abort the clear immediately; no clr_done pulse is produced.

Verification
REQ-030 Scan-out: preload addr 161=0xF00; p_tick at x=4,y=4 with video_on=1 -> mem_addr=161, we=0; rgb=0xF00 exactly 2 clk later.
REQ-031 Blanking: p_tick with video_on=0 -> mem_en=0 on that clk; rgb=0x000 2 clk later; a pending wr_req is acked on that same p_tick clk.
REQ-032 Priority: wr_req held across a p_tick clk with video_on=1 -> no wr_ack on the tick clk; wr_ack on the next clk with correct addr/data.
REQ-033 Clear: clr_req with clr_color=0x0A5 during active video -> all 19200 cells read back 0x0A5; busy high throughout; exactly one clr_done; the count of clear writes is 19200.
REQ-034 Bounds and stall: wr_addr=19200 -> wr_ack pulses with mem_en=0; wr_req issued during CLEAR -> acked only after clr_done.
REQ-035 Reset mid-clear at counter=500 -> busy=0 and rgb=0 on the next clk; no clr_done; a new clr_req restarts the clear from address 0.
